// File: rtl/zeroriscy_dma_pkg.sv
// Shared types and constants for the zero-riscy DMA master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zeroriscy_dma_pkg;

  // Transfer engine states; DONE is the single-cycle completion slot.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    ERR     = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam logic [3:0]  BE_WORD    = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/zeroriscy_dma_master.sv
// Word copy / word fill initiator on the zero-riscy req/gnt/rvalid data bus.
// Latency: 1 cycle start->first request; copy 4 cycles/word, fill 2 cycles/word with an ideal responder.
// Backpressure: request fields held until m_gnt; one transaction outstanding, waits for m_rvalid.
//
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   cfg_start/fill/src/dst/len/pattern/abort   job configuration, latched on an accepted start
//   busy, done, error, err_addr, words_done    job status
//   m_req/we/be/addr/wdata -> m_gnt/rvalid/rdata/err   memory bus initiator
module zeroriscy_dma_master
  import zeroriscy_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_fill,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [31:0]      cfg_pattern,
  input  logic             cfg_abort,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      err_addr,
  output logic [LEN_W-1:0] words_done,
  output logic             m_req,
  output logic             m_we,
  output logic [3:0]       m_be,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic             m_gnt,
  input  logic             m_rvalid,
  input  logic [31:0]      m_rdata,
  input  logic             m_err
);

  state_e           state_q, state_d;
  logic             fill_q, fill_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      pattern_q, pattern_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic             error_q, error_d;
  logic [31:0]      err_addr_q, err_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fill_q     <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      pattern_q  <= '0;
      data_q     <= '0;
      words_q    <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      pattern_q  <= pattern_d;
      data_q     <= data_d;
      words_q    <= words_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    pattern_d  = pattern_q;
    data_d     = data_q;
    words_d    = words_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;

    unique case (state_q)
      IDLE: begin
        // Start is only accepted here, so a start while busy has no effect.
        if (cfg_start) begin
          fill_d    = cfg_fill;
          src_d     = cfg_src & ~32'h3;
          dst_d     = cfg_dst & ~32'h3;
          len_d     = cfg_len;
          pattern_d = cfg_pattern;
          words_d   = '0;
          error_d   = 1'b0;
          if (cfg_len == '0)  state_d = DONE;
          else if (cfg_fill)  state_d = WR_REQ;
          else                state_d = RD_REQ;
        end
      end
      RD_REQ:  if (m_gnt) state_d = RD_WAIT;
      RD_WAIT: begin
        if (m_rvalid) begin
          if (m_err) begin
            error_d    = 1'b1;
            err_addr_d = src_q;
            state_d    = ERR;
          end else begin
            data_d  = m_rdata;
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ:  if (m_gnt) state_d = WR_WAIT;
      WR_WAIT: begin
        if (m_rvalid) begin
          if (m_err) begin
            // The faulting word is not counted and addresses stay on it.
            error_d    = 1'b1;
            err_addr_d = dst_q;
            state_d    = ERR;
          end else begin
            words_d = words_q + LEN_W'(1);
            src_d   = src_q + WORD_BYTES;
            dst_d   = dst_q + WORD_BYTES;
            // Abort is only honoured at a word boundary, i.e. at a write ack.
            if ((words_q + LEN_W'(1) == len_q) || cfg_abort) state_d = DONE;
            else if (fill_q)                                 state_d = WR_REQ;
            else                                             state_d = RD_REQ;
          end
        end
      end
      ERR:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are decoded straight from registered state so they are
  // stable for the whole request phase and drop as soon as reset asserts.
  assign m_req      = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign m_we       = (state_q == WR_REQ);
  assign m_be       = m_req ? BE_WORD : 4'h0;
  assign m_addr     = (state_q == RD_REQ) ? src_q :
                      (state_q == WR_REQ) ? dst_q : 32'h0;
  assign m_wdata    = (state_q == WR_REQ) ? (fill_q ? pattern_q : data_q) : 32'h0;

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = error_q;
  assign err_addr   = err_addr_q;
  assign words_done = words_q;

endmodule
